// File: rtl/int_res_copy_ctrl.sv
// Strided block-copy initiator for int_res memory: one read per cycle, and returned
// data is written straight through to a destination address stream.
module int_res_copy_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] src_stride,
  input  logic [ADDR_W-1:0] dst_stride,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        width,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_data_width,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic              wr_chip_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        wr_data_width
);

  localparam logic [1:0] SINGLE_WIDTH = 2'd0;

  typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]       src_stride_q, src_stride_d;
  logic [ADDR_W-1:0]       dst_stride_q, dst_stride_d;
  logic [LEN_W-1:0]        rd_left_q, rd_left_d;
  logic [LEN_W-1:0]        wr_left_q, wr_left_d;
  logic [1:0]              width_q, width_d;
  // vld_q[i] set means a read issued i cycles ago is still owed a write
  logic [READ_LATENCY:1]   vld_q, vld_d;
  logic                    active;

  assign active = (state_q == COPY) || (state_q == DRAIN);

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    src_stride_d = src_stride_q;
    dst_stride_d = dst_stride_q;
    rd_left_d    = rd_left_q;
    wr_left_d    = wr_left_q;
    width_d      = width_q;

    rd_en = (state_q == COPY) && !abort;
    wr_en = active && vld_q[READ_LATENCY] && !abort;

    vld_d[1] = rd_en;
    for (int i = 2; i <= READ_LATENCY; i++) vld_d[i] = vld_q[i-1];

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d    = src_addr;
          wr_addr_d    = dst_addr;
          src_stride_d = src_stride;
          dst_stride_d = dst_stride;
          rd_left_d    = len;
          wr_left_d    = len;
          width_d      = width;
          state_d      = (len == '0) ? DONE : COPY;
        end
      end
      COPY: begin
        if (abort) state_d = DONE;
        else begin
          rd_addr_d = rd_addr_q + src_stride_q;
          rd_left_d = rd_left_q - LEN_W'(1);
          if (rd_left_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) state_d = DONE;
        else if (wr_en && wr_left_q == LEN_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      wr_addr_d = wr_addr_q + dst_stride_q;
      wr_left_d = wr_left_q - LEN_W'(1);
    end
    // abort drops whatever is still in flight
    if (active && abort) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      rd_left_q    <= '0;
      wr_left_q    <= '0;
      width_q      <= SINGLE_WIDTH;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      src_stride_q <= src_stride_d;
      dst_stride_q <= dst_stride_d;
      rd_left_q    <= rd_left_d;
      wr_left_q    <= wr_left_d;
      width_q      <= width_d;
      vld_q        <= vld_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign wr_chip_en    = active;
  assign rd_addr       = rd_addr_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_en ? rd_data : '0;
  assign rd_data_width = busy ? width_q : SINGLE_WIDTH;
  assign wr_data_width = busy ? width_q : SINGLE_WIDTH;

endmodule

// File: tb/tb_int_res_copy_ctrl.sv
// Directed bench for int_res_copy_ctrl with a behavioural int_res memory on the read port.
module tb_int_res_copy_ctrl;
  localparam logic [1:0] SW = 2'd0;
  localparam logic [1:0] DW = 2'd1;

  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [15:0] src_addr = 0, dst_addr = 0, src_stride = 0, dst_stride = 0;
  logic [15:0] len = 0;
  logic [1:0]  width = 0;
  logic        busy, done, rd_en, wr_en, wr_chip_en;
  logic [15:0] rd_addr, wr_addr;
  logic [1:0]  rd_data_width, wr_data_width;
  logic [31:0] rd_data = 0, wr_data;

  int n_chk = 0, n_pass = 0;

  int_res_copy_ctrl #(.ADDR_W(16), .DATA_W(32), .LEN_W(16), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .src_stride(src_stride), .dst_stride(dst_stride),
    .len(len), .width(width), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_width(rd_data_width), .rd_data(rd_data),
    .wr_en(wr_en), .wr_chip_en(wr_chip_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_data_width(wr_data_width));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // memory: latch request away from the edge, return data one cycle later
  logic        rq_v;
  logic [15:0] rq_a;
  always @(negedge clk) begin rq_v = rd_en; rq_a = rd_addr; end
  always @(posedge clk) if (rq_v) rd_data <= memf(rq_a);

  logic [15:0] rd_aq[$], wr_aq[$];
  logic [31:0] wr_dq[$];
  logic [1:0]  wr_wq[$], rd_wq[$];
  int busy_cnt, done_cnt;

  always @(negedge clk) if (rst_n) begin
    if (rd_en) begin rd_aq.push_back(rd_addr); rd_wq.push_back(rd_data_width); end
    if (wr_en) begin wr_aq.push_back(wr_addr); wr_dq.push_back(wr_data); wr_wq.push_back(wr_data_width); end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  task automatic clr();
    rd_aq.delete(); rd_wq.delete(); wr_aq.delete(); wr_dq.delete(); wr_wq.delete();
    busy_cnt = 0; done_cnt = 0;
  endtask

  task automatic kick(input logic [15:0] s, d, ss, ds, l, input logic [1:0] w);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; src_stride = ss; dst_stride = ds; len = l; width = w; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // returns cycles from start's sampling edge to done, or 99 on timeout
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if ({busy, done, rd_en, wr_en, wr_chip_en, rd_addr, wr_addr, wr_data, rd_data_width, wr_data_width} !== '0)
      $display("FAIL reset_outs: got busy=%b done=%b rd_en=%b wr_en=%b", busy, done, rd_en, wr_en); else n_pass++;
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    n_chk++; if ({busy, done, rd_en, wr_en, wr_chip_en} !== 5'b0)
      $display("FAIL idle_outs: got %b exp 00000", {busy, done, rd_en, wr_en, wr_chip_en}); else n_pass++;
  endtask

  task automatic test_basic();
    int n;
    clr();
    kick(16'h0010, 16'h0080, 16'd1, 16'd1, 16'd4, SW);
    wait_done(n);
    n_chk++; if (n !== 6) $display("FAIL basic_done_cyc: got %0d exp 6", n); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd_aq.size() !== 4 || wr_aq.size() !== 4)
      $display("FAIL basic_counts: got rd=%0d wr=%0d exp 4/4", rd_aq.size(), wr_aq.size()); else n_pass++;
    for (int k = 0; k < 4 && k < wr_aq.size(); k++) begin
      n_chk++; if (wr_aq[k] !== 16'h0080 + 16'(k) || wr_dq[k] !== memf(16'h0010 + 16'(k)))
        $display("FAIL basic_wr%0d: got %h/%h exp %h/%h", k, wr_aq[k], wr_dq[k], 16'h0080 + 16'(k), memf(16'h0010 + 16'(k)));
      else n_pass++;
    end
    n_chk++; if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d exp 1", done_cnt); else n_pass++;
  endtask

  task automatic test_strided();
    int n;
    clr();
    kick(16'h0000, 16'h0100, 16'd1, 16'd8, 16'd3, DW);
    wait_done(n);
    n_chk++; if (n !== 5) $display("FAIL stride_done_cyc: got %0d exp 5", n); else n_pass++;
    @(negedge clk);
    n_chk++; if (wr_aq.size() !== 3) $display("FAIL stride_wr_cnt: got %0d exp 3", wr_aq.size()); else n_pass++;
    for (int k = 0; k < 3 && k < wr_aq.size(); k++) begin
      n_chk++; if (wr_aq[k] !== 16'h0100 + 16'(8*k) || wr_dq[k] !== memf(16'(k)) || wr_wq[k] !== DW)
        $display("FAIL stride_wr%0d: got %h/%h/w%0d exp %h/%h/w%0d", k, wr_aq[k], wr_dq[k], wr_wq[k], 16'h0100 + 16'(8*k), memf(16'(k)), DW);
      else n_pass++;
    end
    n_chk++; if (rd_wq.size() < 1 || rd_wq[0] !== DW) $display("FAIL stride_rd_width: got %p exp w1", rd_wq); else n_pass++;
  endtask

  task automatic test_zero();
    int n;
    clr();
    kick(16'h0020, 16'h0040, 16'd1, 16'd1, 16'd0, SW);
    wait_done(n);
    n_chk++; if (n !== 1) $display("FAIL zero_done_cyc: got %0d exp 1", n); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (rd_aq.size() !== 0 || wr_aq.size() !== 0)
      $display("FAIL zero_no_access: got rd=%0d wr=%0d exp 0/0", rd_aq.size(), wr_aq.size()); else n_pass++;
    n_chk++; if (busy_cnt !== 1) $display("FAIL zero_busy_cyc: got %0d exp 1", busy_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    int n;
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    clr();
    kick(16'hFFFE, 16'h0200, 16'd1, 16'd1, 16'd4, SW);
    wait_done(n);
    @(negedge clk);
    n_chk++; if (rd_aq.size() !== 4) $display("FAIL wrap_rd_cnt: got %0d exp 4", rd_aq.size()); else n_pass++;
    for (int k = 0; k < 4 && k < rd_aq.size(); k++) begin
      n_chk++; if (rd_aq[k] !== exp_a[k]) $display("FAIL wrap_rd%0d: got %h exp %h", k, rd_aq[k], exp_a[k]); else n_pass++;
    end
    n_chk++; if (wr_dq.size() !== 4 || wr_dq[2] !== memf(16'h0000))
      $display("FAIL wrap_wr_data: got %p exp [2]=%h", wr_dq, memf(16'h0000)); else n_pass++;
  endtask

  task automatic test_abort();
    int n;
    clr();
    kick(16'h0060, 16'h0600, 16'd1, 16'd1, 16'd10, SW);
    @(posedge clk); #1;
    @(posedge clk); #1; abort = 1;
    #1;
    n_chk++; if (rd_en !== 1'b0 || wr_en !== 1'b0)
      $display("FAIL abort_same_cyc: got rd_en=%b wr_en=%b exp 0/0", rd_en, wr_en); else n_pass++;
    @(posedge clk); #1; abort = 0;
    #1;
    n_chk++; if (done !== 1'b1) $display("FAIL abort_done: got %b exp 1", done); else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++; if (rd_aq.size() !== 2 || wr_aq.size() !== 1 || done_cnt !== 1)
      $display("FAIL abort_counts: got rd=%0d wr=%0d done=%0d exp 2/1/1", rd_aq.size(), wr_aq.size(), done_cnt); else n_pass++;
    n_chk++; if (wr_aq.size() < 1 || wr_aq[0] !== 16'h0600 || wr_dq[0] !== memf(16'h0060))
      $display("FAIL abort_wr0: got %p exp 0600", wr_aq); else n_pass++;
    clr();
    kick(16'h0070, 16'h0700, 16'd1, 16'd1, 16'd2, SW);
    wait_done(n);
    @(negedge clk);
    n_chk++; if (n !== 4 || wr_aq.size() !== 2) $display("FAIL abort_restart: got cyc=%0d wr=%0d exp 4/2", n, wr_aq.size()); else n_pass++;
    n_chk++; if (wr_aq.size() < 2 || wr_aq[1] !== 16'h0701 || wr_dq[1] !== memf(16'h0071))
      $display("FAIL abort_restart_wr1: got %p exp 0701", wr_aq); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    clr();
    kick(16'h0030, 16'h0300, 16'd1, 16'd1, 16'd4, DW);
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (wr_en !== 1'b1 || rd_en !== 1'b0)
      $display("FAIL rst_mid_drain: got wr_en=%b rd_en=%b exp 1/0", wr_en, rd_en); else n_pass++;
    rst_n = 0;
    #1;
    n_chk++; if ({busy, done, rd_en, wr_en, wr_chip_en, rd_addr, wr_addr, wr_data, rd_data_width, wr_data_width} !== '0)
      $display("FAIL rst_mid_outs: got busy=%b wr_en=%b wr_addr=%h w=%0d", busy, wr_en, wr_addr, wr_data_width); else n_pass++;
    @(negedge clk); rst_n = 1;
    clr();
    kick(16'h0050, 16'h0500, 16'd1, 16'd1, 16'd2, SW);
    wait_done(n);
    @(negedge clk);
    n_chk++; if (n !== 4 || wr_aq.size() !== 2) $display("FAIL rst_restart: got cyc=%0d wr=%0d exp 4/2", n, wr_aq.size()); else n_pass++;
    n_chk++; if (wr_aq.size() < 2 || wr_aq[0] !== 16'h0500 || wr_dq[1] !== memf(16'h0051))
      $display("FAIL rst_restart_data: got %p exp 0500,0501", wr_aq); else n_pass++;
  endtask

  initial begin
    clr();
    test_reset();
    test_basic();
    test_strided();
    test_zero();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
